sv_pipe_alu: RTL and testbench
==============================

Name: sv_pipe_alu

Overview:
- Parametrised successor to the single-function registered adder at the top level.
- Accepts operand pairs over a valid/ready handshake and computes one of four modes: offset sum, subtract, accumulate, or read-and-clear accumulator.
- Presents a registered result with a carry/borrow flag.
- Sits between the input pin bundle and the output pins in the top level; width is generic so the same block serves 8-bit pins and wider internal use.

Parameters:
- W, 8, operand/result/accumulator width in bits (2..32).
- INC, 1, constant added in SUM mode; truncated to W bits.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  operand beat offered
- in_ready  out  1  block can accept operand beat
- a  in  W  operand A
- b  in  W  operand B (ignored in ACC and CLR modes)
- mode  in  2  operation: 0 SUM, 1 SUB, 2 ACC, 3 CLR
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer accepts result
- result  out  W  registered result
- flag  out  1  registered carry (SUM/ACC) or borrow (SUB); 0 in CLR
- acc  out  W  current accumulator value (registered)

Behaviour:
- Reset (rst_n low at a clock edge): result=0, flag=0, out_valid=0, acc=0. in_ready is forced 0 while rst_n is low. Reset mid-transaction discards any held result and the accumulator.
- Handshake rules:
  - in_ready = rst_n & (!out_valid | out_ready). This is a single pipeline register with pass-through back-pressure.
  - Input accept = in_valid & in_ready. Output consume = out_valid & out_ready.
  - Accept and consume in the same cycle is legal: the new result replaces the old one and out_valid stays 1.
  - Consume without accept: out_valid becomes 0; result and flag hold their last values.
  - Neither accept nor consume: all registers hold. a, b and mode are sampled only on accept.
- Latency: 1 cycle from accept to out_valid. Throughput is one beat per cycle while out_ready is held high.
- Arithmetic: internal W+1-bit sums, all unsigned.
  - SUM: r = a + b + INC; flag = bit W.
  - SUB: r = a - b; flag = (a < b).
  - ACC: r = acc + a; flag = bit W; acc <= r (after saturation if enabled) on accept only.
  - CLR: r = acc; flag = 0; acc <= 0 on accept.
- Without saturation, results wrap modulo 2^W.
- acc changes only on an accepted ACC or CLR beat. SUM and SUB never touch acc.
- Back-to-back ACC beats chain through the updated acc with no bubble.

Optional Feature:
- Macro: SV_PIPE_ALU_SATURATE_EN.
- Defined:
  - SUM/ACC overflow clamps r to all-ones (2^W-1).
  - SUB underflow clamps r to 0.
  - flag still reports the carry/borrow.
  - The clamped value is what is stored into acc.
- Undefined: wrap-around arithmetic, with no clamp logic synthesised.

Decomposition:
- Package sv_alu_pkg holds:
  - mode_e enum (2-bit): MODE_SUM=0, MODE_SUB=1, MODE_ACC=2, MODE_CLR=3.
  - Localparam default width 8.
- One sub-module, sv_alu_core: purely combinational, parametrised by W and INC. It takes a, b, acc and mode and returns the next result, flag and acc. Saturation under the same macro lives here.
- The top sv_pipe_alu owns all registers and the handshake.

Test Plan (W=8, INC=1):
1. Reset then SUM: a=0x10, b=0x20, out_ready=1 -> next cycle result=0x31, flag=0, out_valid=1. Hold rst_n low 1 cycle mid-stream -> result=0, out_valid=0, acc=0, in_ready=0.
2. SUM overflow: a=0xFF, b=0x01 -> wrap build: result=0x01, flag=1. SATURATE_EN build: result=0xFF, flag=1.
3. SUB: a=0x05, b=0x07 -> wrap: result=0xFE, flag=1. Saturate: result=0x00, flag=1. a=0x07, b=0x05 -> result=0x02, flag=0.
4. ACC chain: ACC a=0x80, then ACC a=0x90 back-to-back -> results 0x80 (flag 0) then 0x10 (flag 1), acc=0x10. Saturate build: second result=0xFF, acc=0xFF. Follow with CLR -> result equals prior acc, flag=0, acc=0x00.
5. Back-pressure: out_ready=0 after one accepted beat -> in_ready=0, result stable for 5 cycles with in_valid held high and a changing. Raise out_ready -> simultaneous consume and accept, out_valid stays 1, new result 1 cycle later.
6. Non-accepted ACC: mode=ACC, in_valid=1 while in_ready=0 -> acc unchanged until the beat is actually accepted.

Source files
------------

// File: rtl/sv_alu_pkg.sv
// sv_alu_pkg: shared mode encoding and default width for the pipelined ALU
package sv_alu_pkg;
  typedef enum logic [1:0] {
    MODE_SUM = 2'd0,
    MODE_SUB = 2'd1,
    MODE_ACC = 2'd2,
    MODE_CLR = 2'd3
  } mode_e;
  localparam int DEF_W = 8;
endpackage

// File: rtl/sv_alu_core.sv
// sv_alu_core: combinational next-result/flag/accumulator datapath
// SV_PIPE_ALU_SATURATE_EN clamps overflow to all-ones and underflow to zero
module sv_alu_core
  import sv_alu_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int INC = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_acc,
  input  logic [1:0]   i_mode,
  output logic [W-1:0] o_r,
  output logic         o_flag,
  output logic [W-1:0] o_acc_nxt
);
  localparam logic [W-1:0] INC_W = W'(INC);
  logic [W:0] w_sum;
  logic [W:0] w_sub;
  logic [W:0] w_add;
  logic [W:0] w_raw;
  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {1'b0, INC_W};
  assign w_sub = {1'b0, i_a} - {1'b0, i_b};
  assign w_add = {1'b0, i_acc} + {1'b0, i_a};
  assign w_raw = i_mode == MODE_SUB ? w_sub : i_mode == MODE_ACC ? w_add : w_sum;
  assign o_flag = i_mode == MODE_CLR ? 1'b0 : w_raw[W];
`ifdef SV_PIPE_ALU_SATURATE_EN
  // bit W is carry for additions and borrow for subtraction
  assign o_r = i_mode == MODE_CLR ? i_acc :
               !w_raw[W]          ? w_raw[W-1:0] :
               i_mode == MODE_SUB ? '0 : '1;
`else
  assign o_r = i_mode == MODE_CLR ? i_acc : w_raw[W-1:0];
`endif
  assign o_acc_nxt = i_mode == MODE_ACC ? o_r : i_mode == MODE_CLR ? '0 : i_acc;
endmodule

// File: rtl/sv_pipe_alu.sv
// sv_pipe_alu: single-register valid/ready ALU stage with accumulator
// optional SV_PIPE_ALU_SATURATE_EN selects clamping arithmetic in sv_alu_core
module sv_pipe_alu
  import sv_alu_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int INC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag,
  output logic [W-1:0] acc
);
  logic [W-1:0] r_result;
  logic         r_flag;
  logic         r_valid;
  logic [W-1:0] r_acc;
  logic [W-1:0] w_r;
  logic         w_flag;
  logic [W-1:0] w_acc_nxt;
  logic         w_accept;
  sv_alu_core #(.W(W), .INC(INC)) u_core (
    .i_a       (a),
    .i_b       (b),
    .i_acc     (r_acc),
    .i_mode    (mode),
    .o_r       (w_r),
    .o_flag    (w_flag),
    .o_acc_nxt (w_acc_nxt)
  );
  assign in_ready  = rst_n & (!r_valid | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_valid;
  assign result    = r_result;
  assign flag      = r_flag;
  assign acc       = r_acc;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flag   <= 1'b0;
      r_valid  <= 1'b0;
      r_acc    <= '0;
    end else if (w_accept) begin
      r_result <= w_r;
      r_flag   <= w_flag;
      r_valid  <= 1'b1;
      r_acc    <= w_acc_nxt;
    end else if (out_ready) begin
      r_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sv_pipe_alu.sv
// tb_sv_pipe_alu: directed plus randomized checks against a transaction-level model
module tb_sv_pipe_alu;
  localparam int W   = 8;
  localparam int INC = 1;
  localparam int MAX = (1 << W) - 1;
`ifdef SV_PIPE_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         flag;
  logic [W-1:0] acc;
  int errors = 0;
  int checks = 0;
  int m_result = 0, m_acc = 0;
  bit m_flag = 0, m_valid = 0;

  sv_pipe_alu #(.W(W), .INC(INC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag      (flag),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, "_result"}, 32'(result), 32'(m_result));
    check({tag, "_flag"}, 32'(flag), 32'(m_flag));
    check({tag, "_acc"}, 32'(acc), 32'(m_acc));
  endtask

  // one clock of stimulus; the model decides acceptance from the handshake rules
  task automatic step(input bit v, input int av, input int bv, input int md, input bit ordy, input string tag);
    int s;
    bit take;
    @(negedge clk);
    rst_n = 1'b1; in_valid = v; a = W'(av); b = W'(bv); mode = 2'(md); out_ready = ordy;
    #1;
    take = v && (!m_valid || ordy);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(!m_valid || ordy));
    if (take) begin
      case (md)
        0: s = av + bv + (INC % (MAX + 1));
        1: s = av - bv;
        2: s = m_acc + av;
        default: s = m_acc;
      endcase
      m_flag = (md == 1) ? (s < 0) : (md == 3) ? 1'b0 : (s > MAX);
      m_result = SAT ? ((s > MAX) ? MAX : (s < 0) ? 0 : s) : (s & MAX);
      if (md == 2) m_acc = m_result;
      if (md == 3) m_acc = 0;
      m_valid = 1;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_rst_in_ready"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    m_result = 0; m_flag = 0; m_valid = 0; m_acc = 0;
    check_outs(tag);
  endtask

  initial begin
    do_reset("reset0");
    // plain SUM, then reset mid-stream
    step(1, 'h10, 'h20, 0, 1, "sum");
    check("sum_const", 32'(result), 32'h31);
    step(1, 'h03, 'h04, 2, 1, "acc_pre");
    step(1, 'h11, 'h22, 0, 0, "pre_rst");
    do_reset("midrst");
    // SUM overflow
    step(1, 'hFF, 'h01, 0, 1, "sum_ovf");
    check("sum_ovf_const", 32'(result), SAT ? 32'hFF : 32'h01);
    // SUB underflow and normal
    step(1, 'h05, 'h07, 1, 1, "sub_unf");
    check("sub_unf_const", 32'(result), SAT ? 32'h00 : 32'hFE);
    step(1, 'h07, 'h05, 1, 1, "sub");
    check("sub_const", 32'(result), 32'h02);
    // ACC chain back-to-back, then CLR
    step(1, 'h80, 'h33, 2, 1, "acc1");
    check("acc1_const", 32'(result), 32'h80);
    step(1, 'h90, 'h44, 2, 1, "acc2");
    check("acc2_const", 32'(acc), SAT ? 32'hFF : 32'h10);
    step(1, 'h12, 'h34, 3, 1, "clr");
    check("clr_const", 32'(result), SAT ? 32'hFF : 32'h10);
    // back-pressure with a pending ACC beat that must not be taken
    step(1, 'h21, 'h00, 2, 0, "bp_acc");
    for (int i = 0; i < 5; i++) step(1, $urandom_range(0, MAX), 0, 2, 0, "bp_hold");
    step(1, 'h05, 'h00, 2, 1, "bp_release");
    step(0, 0, 0, 0, 1, "drain");
    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
      else step(bit'($urandom_range(0, 3) != 0), $urandom_range(0, MAX), $urandom_range(0, MAX),
                $urandom_range(0, 3), bit'($urandom_range(0, 3) != 0), "rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
